// File: rtl/prio_intr_pkg.sv
// Shared types and register map constants for the priority interrupt controller.
package prio_intr_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARB      = 2'd1,
    WAIT_ACK = 2'd2
  } state_e;

  localparam logic [7:0] PEND_BASE   = 8'h40;
  localparam logic [7:0] MODE_BASE   = 8'h60;
  localparam logic [7:0] THRESH_ADDR = 8'h7F;

  function automatic int unsigned num_bytes(input int unsigned n);
    return (n + 7) / 8;
  endfunction

endpackage

// File: rtl/prio_intr_arb.sv
// Combinational max-finder over eligible sources; ties resolve to the lowest index.
module prio_intr_arb
  import prio_intr_pkg::*;
#(
  parameter int NUM_INTR = 16,
  parameter int PRIO_W   = 4,
  parameter int ID_W     = $clog2(NUM_INTR)
) (
  input  logic [NUM_INTR-1:0]             elig_i,
  input  logic [NUM_INTR-1:0][PRIO_W-1:0] prio_i,
  output logic                            found_o,
  output logic [ID_W-1:0]                 id_o,
  output logic [PRIO_W-1:0]               prio_o
);

  logic              found;
  logic [ID_W-1:0]   best_id;
  logic [PRIO_W-1:0] best_prio;

  // Strict '>' keeps the earlier (lower) index on equal priority.
  always_comb begin
    found     = 1'b0;
    best_id   = '0;
    best_prio = '0;
    for (int i = 0; i < NUM_INTR; i++) begin
      if (elig_i[i] && (!found || (prio_i[i] > best_prio))) begin
        found     = 1'b1;
        best_id   = ID_W'(i);
        best_prio = prio_i[i];
      end
    end
  end

  assign found_o = found;
  assign id_o    = best_id;
  assign prio_o  = best_prio;

endmodule

// File: rtl/prio_intr_ctrl.sv
// APB-programmable priority interrupt controller: per-source priority, level/edge mode,
// global threshold, and a valid/serviced handshake towards the processor.
module prio_intr_ctrl
  import prio_intr_pkg::*;
#(
  parameter int NUM_INTR = 16,
  parameter int PRIO_W   = 4,
  localparam int ID_W    = $clog2(NUM_INTR)
) (
  input  logic                pclk_i,
  input  logic                prst_n_i,
  input  logic                psel_i,
  input  logic                penable_i,
  input  logic                pwrite_i,
  input  logic [7:0]          paddr_i,
  input  logic [7:0]          pwdata_i,
  output logic [7:0]          prdata_o,
  output logic                pready_o,
  output logic                pslverr_o,
  input  logic [NUM_INTR-1:0] intr_active_i,
  output logic [ID_W-1:0]     intr_to_service_o,
  output logic [PRIO_W-1:0]   intr_prio_o,
  output logic                intr_valid_o,
  input  logic                intr_serviced_i
);

  localparam int NB = num_bytes(NUM_INTR);

  logic [NUM_INTR-1:0][PRIO_W-1:0] prio_q;
  logic [NUM_INTR-1:0]             mode_q;
  logic [PRIO_W-1:0]               thresh_q;
  logic [NUM_INTR-1:0]             pend_q, pend_d;
  logic [NUM_INTR-1:0]             prev_q;
  state_e                          state_q, state_d;
  logic [ID_W-1:0]                 id_q, id_d;
  logic [PRIO_W-1:0]               iprio_q, iprio_d;
  logic                            valid_q, valid_d;

  logic                access, wr_acc, hit;
  logic [7:0]          rdata;
  logic [NUM_INTR-1:0] prio_we, mode_we, w1c;
  logic [NB-1:0]       pend_sel, mode_sel;
  logic                thresh_we;
  logic [NB*8-1:0]     pend_pad, mode_pad;

  logic [NUM_INTR-1:0] elig, id_onehot;
  logic                other_elig, svc_clr;
  logic                win_found;
  logic [ID_W-1:0]     win_id;
  logic [PRIO_W-1:0]   win_prio;

  assign access   = psel_i & penable_i;
  assign wr_acc   = access & pwrite_i;
  assign pend_pad = (NB*8)'(pend_q);
  assign mode_pad = (NB*8)'(mode_q);

  always_comb begin
    hit       = 1'b0;
    rdata     = '0;
    prio_we   = '0;
    pend_sel  = '0;
    mode_sel  = '0;
    thresh_we = 1'b0;
    for (int i = 0; i < NUM_INTR; i++) begin
      if (paddr_i == 8'(i)) begin
        hit               = 1'b1;
        rdata[PRIO_W-1:0] = prio_q[i];
        prio_we[i]        = wr_acc;
      end
    end
    for (int k = 0; k < NB; k++) begin
      if (paddr_i == PEND_BASE + 8'(k)) begin
        hit         = 1'b1;
        rdata       = pend_pad[k*8 +: 8];
        pend_sel[k] = 1'b1;
      end
      if (paddr_i == MODE_BASE + 8'(k)) begin
        hit         = 1'b1;
        rdata       = mode_pad[k*8 +: 8];
        mode_sel[k] = 1'b1;
      end
    end
    if (paddr_i == THRESH_ADDR) begin
      hit               = 1'b1;
      rdata[PRIO_W-1:0] = thresh_q;
      thresh_we         = wr_acc;
    end
  end

  // Byte-lane selects expanded to per-source enables; W1C only touches edge-mode bits.
  always_comb begin
    mode_we = '0;
    w1c     = '0;
    for (int i = 0; i < NUM_INTR; i++) begin
      mode_we[i] = wr_acc & mode_sel[i/8];
      w1c[i]     = wr_acc & pend_sel[i/8] & pwdata_i[i%8] & mode_q[i];
    end
  end

  assign pready_o  = access;
  assign prdata_o  = access ? rdata : 8'h00;
  assign pslverr_o = access & ~hit;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_INTR; i++) begin
      elig[i] = pend_q[i] & (prio_q[i] != '0) & (prio_q[i] > thresh_q);
    end
  end

  assign id_onehot  = NUM_INTR'(1) << id_q;
  assign other_elig = |(elig & ~id_onehot);

  prio_intr_arb #(
    .NUM_INTR (NUM_INTR),
    .PRIO_W   (PRIO_W),
    .ID_W     (ID_W)
  ) u_arb (
    .elig_i  (elig),
    .prio_i  (prio_q),
    .found_o (win_found),
    .id_o    (win_id),
    .prio_o  (win_prio)
  );

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    iprio_d = iprio_q;
    valid_d = valid_q;
    svc_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|elig) state_d = ARB;
      end
      ARB: begin
        if (win_found) begin
          id_d    = win_id;
          iprio_d = win_prio;
          valid_d = 1'b1;
          state_d = WAIT_ACK;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_ACK: begin
        if (intr_serviced_i) begin
          valid_d = 1'b0;
          id_d    = '0;
          iprio_d = '0;
          svc_clr = 1'b1;
          state_d = other_elig ? ARB : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A fresh rising edge beats a same-cycle service or W1C clear.
  always_comb begin
    pend_d = '0;
    for (int i = 0; i < NUM_INTR; i++) begin
      if (mode_q[i]) begin
        pend_d[i] = (intr_active_i[i] & ~prev_q[i]) |
                    (pend_q[i] & ~(w1c[i] | (svc_clr & id_onehot[i])));
      end else begin
        pend_d[i] = intr_active_i[i];
      end
    end
  end

  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      prio_q   <= '0;
      mode_q   <= '0;
      thresh_q <= '0;
      pend_q   <= '0;
      prev_q   <= '0;
      state_q  <= IDLE;
      id_q     <= '0;
      iprio_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_INTR; i++) begin
        if (prio_we[i]) prio_q[i] <= pwdata_i[PRIO_W-1:0];
        if (mode_we[i]) mode_q[i] <= pwdata_i[i%8];
      end
      if (thresh_we) thresh_q <= pwdata_i[PRIO_W-1:0];
      pend_q  <= pend_d;
      prev_q  <= intr_active_i;
      state_q <= state_d;
      id_q    <= id_d;
      iprio_q <= iprio_d;
      valid_q <= valid_d;
    end
  end

  assign intr_to_service_o = id_q;
  assign intr_prio_o       = iprio_q;
  assign intr_valid_o      = valid_q;

endmodule
